// File: rtl/ceil_div_seq.sv
// ceil_div_seq: sequential ceil(dividend / divisor), radix-2 restoring.
// Option: CEIL_DIV_SEQ_EARLY_EXIT_EN skips the loop when dividend <= divisor.
module ceil_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic             div_by_zero_o
);

`ifndef COMMON_CELLS_ASSERTS_OFF
    if (WIDTH < 2) begin : g_width_chk
        $fatal(1, "ceil_div_seq: WIDTH must be at least 2");
    end
`endif

    localparam int unsigned CNT_W =
        (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ROUND,
        DONE
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             dbz_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             zero_dvs;
    logic             last_iter;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] sub;
    logic             take;

    assign accept    = valid_i && ready_o;
    assign zero_dvs  = (divisor_i == '0);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Shift the next dividend bit into the remainder and try a subtract.
    // The remainder is always below the divisor, so the low WIDTH bits
    // of the difference are exact whenever the subtract is taken.
    assign trial = {rem_q, dvd_q[WIDTH-1]};
    assign take  = (trial >= {1'b0, dvs_q});
    assign sub   = trial[WIDTH-1:0] - dvs_q;

`ifdef CEIL_DIV_SEQ_EARLY_EXIT_EN
    logic early;
    assign early = (dividend_i <= divisor_i);
`else
    logic early;
    assign early = 1'b0;
`endif

    assign quotient_o    = quo_q;
    assign div_by_zero_o = dbz_q;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    if (zero_dvs || early) begin
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Operand capture, quotient bit generation and round-up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        dvd_q <= dividend_i;
                        dvs_q <= divisor_i;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (zero_dvs) begin
                            quo_q <= '1;
                            dbz_q <= 1'b1;
                        end else if (early) begin
                            quo_q <= WIDTH'(dividend_i != '0);
                            dbz_q <= 1'b0;
                        end else begin
                            quo_q <= '0;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_q <= take ? sub : trial[WIDTH-1:0];
                    dvd_q <= dvd_q << 1;
                    quo_q <= {quo_q[WIDTH-2:0], take};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ROUND: begin
                    if (rem_q != '0) begin
                        quo_q <= quo_q + WIDTH'(1);
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceil_div_seq.sv
// tb_ceil_div_seq: directed vector bench for ceil_div_seq at WIDTH = 8.
// Checks results, latency, backpressure and mid-operation reset.
module tb_ceil_div_seq;

    localparam int W = 8;

`ifdef CEIL_DIV_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] quotient_o;
    logic         div_by_zero_o;

    int checks;
    int failures;

    ceil_div_seq #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .quotient_o    (quotient_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic         dbz;
        logic         ee;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready_o before"}, 32'(ready_o), 1);
        valid_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        dividend_i = W'($urandom);
        divisor_i  = W'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_o && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        chk({tag, " valid_o after"}, 32'(valid_o), 0);
        chk({tag, " ready_o after"}, 32'(ready_o), 1);
    endtask

    task automatic run_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] q,
                          input logic dbz,
                          input int lat_exp,
                          input string tag);
        int lat;
        issue(a, b, tag);
        wait_valid(lat);
        chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, " quotient"}, 32'(quotient_o), 32'(q));
        chk({tag, " dbz"}, 32'(div_by_zero_o), 32'(dbz));
        chk({tag, " ready_o busy"}, 32'(ready_o), 0);
        release_out(tag);
    endtask

    initial begin
        int lat;
        int lat_exp;
        logic [W-1:0] held;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;

        vecs[0]  = '{8'd7,   8'd2,   8'd4,   1'b0, 1'b0};
        vecs[1]  = '{8'd8,   8'd2,   8'd4,   1'b0, 1'b0};
        vecs[2]  = '{8'd255, 8'd1,   8'd255, 1'b0, 1'b0};
        vecs[3]  = '{8'd255, 8'd254, 8'd2,   1'b0, 1'b0};
        vecs[4]  = '{8'd0,   8'd5,   8'd0,   1'b0, 1'b1};
        vecs[5]  = '{8'd200, 8'd0,   8'hFF,  1'b1, 1'b0};
        vecs[6]  = '{8'd9,   8'd4,   8'd3,   1'b0, 1'b0};
        vecs[7]  = '{8'd3,   8'd7,   8'd1,   1'b0, 1'b1};
        vecs[8]  = '{8'd7,   8'd7,   8'd1,   1'b0, 1'b1};
        vecs[9]  = '{8'd0,   8'd3,   8'd0,   1'b0, 1'b1};
        vecs[10] = '{8'd1,   8'd255, 8'd1,   1'b0, 1'b1};
        vecs[11] = '{8'd255, 8'd255, 8'd1,   1'b0, 1'b1};
        vecs[12] = '{8'd128, 8'd3,   8'd43,  1'b0, 1'b0};
        vecs[13] = '{8'd5,   8'd3,   8'd2,   1'b0, 1'b0};
        vecs[14] = '{8'd100, 8'd7,   8'd15,  1'b0, 1'b0};
        vecs[15] = '{8'd0,   8'd0,   8'hFF,  1'b1, 1'b0};

        #12;
        chk("reset valid_o", 32'(valid_o), 0);
        chk("reset ready_o", 32'(ready_o), 1);
        chk("reset quotient", 32'(quotient_o), 0);
        chk("reset dbz", 32'(div_by_zero_o), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].dbz) begin
                lat_exp = 1;
            end else if (vecs[i].ee && EE) begin
                lat_exp = 1;
            end else begin
                lat_exp = W + 2;
            end
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q,
                   vecs[i].dbz, lat_exp,
                   $sformatf("vec%0d", i));
        end

        issue(8'd13, 8'd4, "bp");
        wait_valid(lat);
        chk("bp latency", 32'(lat), W + 2);
        chk("bp quotient", 32'(quotient_o), 4);
        held = quotient_o;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            valid_i    = 1'b1;
            dividend_i = 8'd250;
            divisor_i  = 8'd0;
            @(posedge clk);
            #1;
            chk($sformatf("bp hold q c%0d", c),
                32'(quotient_o), 32'(held));
            chk($sformatf("bp hold valid c%0d", c),
                32'(valid_o), 1);
            chk($sformatf("bp hold ready c%0d", c),
                32'(ready_o), 0);
            chk($sformatf("bp hold dbz c%0d", c),
                32'(div_by_zero_o), 0);
        end
        @(negedge clk);
        valid_i = 1'b0;
        release_out("bp");

        issue(8'd100, 8'd7, "rst");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst valid_o", 32'(valid_o), 0);
        chk("rst ready_o", 32'(ready_o), 1);
        chk("rst quotient", 32'(quotient_o), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd100, 8'd7, 8'd15, 1'b0, W + 2, "post rst");

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
